// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencing controller:
// stall vectors, exception codes, FSM states, redirect mapping.
package pipe_ctrl_pkg;

  localparam int RegBus = 32;

  localparam logic              RstEnable = 1'b1;
  localparam logic [RegBus-1:0] ZeroWord  = 32'h0000_0000;

  // bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [RegBus-1:0] EXC_INT     = 32'h0000_0001;
  localparam logic [RegBus-1:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [RegBus-1:0] EXC_INV     = 32'h0000_000a;
  localparam logic [RegBus-1:0] EXC_OV      = 32'h0000_000c;
  localparam logic [RegBus-1:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [RegBus-1:0] EXC_ERET    = 32'h0000_000e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  // Redirect target for a nonzero exception code.
  // Unknown nonzero codes fall back to the exception vector.
  function automatic logic [RegBus-1:0] exc_target(
    input logic [RegBus-1:0] code,
    input logic [RegBus-1:0] epc,
    input logic [RegBus-1:0] exc_vec,
    input logic [RegBus-1:0] int_vec
  );
    logic [RegBus-1:0] pc;
    case (code)
      EXC_INT:     pc = int_vec;
      EXC_ERET:    pc = epc;
      EXC_SYSCALL,
      EXC_INV,
      EXC_OV,
      EXC_TRAP:    pc = exc_vec;
      default:     pc = exc_vec;
    endcase
    return pc;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Stall watchdog: counts consecutive stalled cycles, pulses once
// at STALL_TIMEOUT, keeps a sticky flag until reset.
// Ports: clk, rst (sync, high), stalled in;
//        stall_timeout (pulse), stall_timeout_sticky out.
module stall_watchdog
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_W         = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic stalled,
  output logic stall_timeout,
  output logic stall_timeout_sticky
);

  localparam logic [CNT_W-1:0] LIMIT =
    CNT_W'(STALL_TIMEOUT);
  localparam logic [CNT_W-1:0] FIRE  =
    CNT_W'(STALL_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;
  logic             sticky;
  logic             pulse;

  // cnt holds the number of earlier consecutive stalled
  // cycles, so the pulse lands on the STALL_TIMEOUT-th one.
  // Saturating one past FIRE keeps it from repeating.
  assign pulse = stalled && (cnt == FIRE);

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      cnt    <= '0;
      sticky <= 1'b0;
    end else begin
      if (!stalled) begin
        cnt <= '0;
      end else if (cnt != LIMIT) begin
        cnt <= cnt + 1'b1;
      end
      if (pulse) begin
        sticky <= 1'b1;
      end
    end
  end

  assign stall_timeout        = pulse;
  assign stall_timeout_sticky = sticky | pulse;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall vector, exception
// flush/redirect (deferred behind MEM stalls), stall watchdog.
// Ports: clk, rst, stallreq_from_{if,id,ex,mem}, excepttype_i,
//        cp0_epc_i in; stall, flush, new_pc, stall_timeout,
//        stall_timeout_sticky out.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0040,
  parameter logic [31:0] INT_VECTOR    = 32'h0000_0020,
  parameter int          STALL_TIMEOUT = 1024,
  parameter int          CNT_W         = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_from_if,
  input  logic              stallreq_from_id,
  input  logic              stallreq_from_ex,
  input  logic              stallreq_from_mem,
  input  logic [RegBus-1:0] excepttype_i,
  input  logic [RegBus-1:0] cp0_epc_i,
  output logic [5:0]        stall,
  output logic              flush,
  output logic [RegBus-1:0] new_pc,
  output logic              stall_timeout,
  output logic              stall_timeout_sticky
);

  state_t            state, state_n;
  logic              flush_q, flush_n;
  logic [RegBus-1:0] pc_q, pc_n;
  logic [RegBus-1:0] pend_code, pend_code_n;
  logic [RegBus-1:0] pend_pc, pend_pc_n;
  logic [RegBus-1:0] exc_pc;
  logic              exc_seen;

  assign exc_seen = (excepttype_i != ZeroWord);
  assign exc_pc   = exc_target(excepttype_i, cp0_epc_i,
                               EXC_VECTOR, INT_VECTOR);

  always_comb begin
    stall = STALL_NONE;
    if (rst != RstEnable && state != ST_FLUSH) begin
      priority case (1'b1)
        stallreq_from_mem: stall = STALL_MEM;
        stallreq_from_ex:  stall = STALL_EX;
        stallreq_from_id:  stall = STALL_ID;
        stallreq_from_if:  stall = STALL_IF;
        default:           stall = STALL_NONE;
      endcase
    end
  end

  always_comb begin
    state_n     = state;
    flush_n     = 1'b0;
    pc_n        = pc_q;
    pend_code_n = pend_code;
    pend_pc_n   = pend_pc;
    unique case (state)
      ST_RUN: begin
        if (exc_seen) begin
          if (stallreq_from_mem) begin
            state_n     = ST_WAIT_MEM;
            pend_code_n = excepttype_i;
            pend_pc_n   = exc_pc;
          end else begin
            state_n = ST_FLUSH;
            flush_n = 1'b1;
            pc_n    = exc_pc;
          end
        end
      end
      ST_WAIT_MEM: begin
        if (!stallreq_from_mem) begin
          pend_code_n = ZeroWord;
          if (pend_code != ZeroWord) begin
            state_n = ST_FLUSH;
            flush_n = 1'b1;
            pc_n    = pend_pc;
          end else begin
            state_n = ST_RUN;
          end
        end
      end
      ST_FLUSH: begin
        state_n = ST_RUN;
      end
      default: begin
        state_n = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state     <= ST_RUN;
      flush_q   <= 1'b0;
      pc_q      <= ZeroWord;
      pend_code <= ZeroWord;
      pend_pc   <= ZeroWord;
    end else begin
      state     <= state_n;
      flush_q   <= flush_n;
      pc_q      <= pc_n;
      pend_code <= pend_code_n;
      pend_pc   <= pend_pc_n;
    end
  end

  assign flush  = flush_q;
  assign new_pc = pc_q;

  stall_watchdog #(
    .STALL_TIMEOUT(STALL_TIMEOUT),
    .CNT_W        (CNT_W)
  ) u_wdog (
    .clk                 (clk),
    .rst                 (rst),
    .stalled             (stall[0]),
    .stall_timeout       (stall_timeout),
    .stall_timeout_sticky(stall_timeout_sticky)
  );

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core. It drives the 6-bit stall vector that freezes PC/IF/ID/EX/MEM/WB pipeline registers, including the ID/EX register. It converts an exception or ERET reported from MEM into a one-cycle flush plus a redirect PC, deferring the flush while a MEM-stage stall is in progress. It also runs a stall watchdog that flags runaway stalls.

Parameters:
EXC_VECTOR, 32'h0000_0040, redirect PC for syscall/trap/overflow/invalid-instruction.
INT_VECTOR, 32'h0000_0020, redirect PC for interrupt.
STALL_TIMEOUT, 1024, consecutive stalled cycles before the watchdog fires; must be >= 2.
CNT_W, 11, stall counter width; must hold STALL_TIMEOUT.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high (`RstEnable = 1'b1`)
stallreq_from_if  in  1  IF stage needs a stall (e.g. instruction fetch wait)
stallreq_from_id  in  1  ID stage needs a stall (load-use hazard)
stallreq_from_ex  in  1  EX stage needs a stall (multi-cycle madd/div)
stallreq_from_mem  in  1  MEM stage needs a stall (data bus wait)
excepttype_i  in  32  MEM-stage exception code; 0 means none
cp0_epc_i  in  32  current CP0 EPC, used for ERET
stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 holds that stage
flush  out  1  registered; clear all pipeline registers this cycle
new_pc  out  32  registered; redirect target, valid only when flush=1
stall_timeout  out  1  one-cycle pulse when the watchdog fires
stall_timeout_sticky  out  1  set with the pulse; cleared only by rst

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) produces:
  - state=RUN, flush=0, new_pc=0, stall_timeout=0, stall_timeout_sticky=0
  - stall counter=0, pending exception cleared
  - stall is forced to 0 while rst=1.
- States are RUN, WAIT_MEM and FLUSH.
- Stall vector is combinational. Priority is mem > ex > id > if:
  - mem: 6'b011111
  - ex: 6'b001111
  - id: 6'b000111
  - if: 6'b000011
  - none: 0
  - stall=0 whenever state=FLUSH, regardless of requests.
- Code-to-PC mapping:
  - 0x1 (interrupt) -> INT_VECTOR
  - 0x8, 0xa, 0xc, 0xd -> EXC_VECTOR
  - 0xe (ERET) -> cp0_epc_i sampled at capture
  - any other nonzero code -> EXC_VECTOR
- Transitions from RUN:
  - excepttype_i!=0 and stallreq_from_mem=0: go to FLUSH and load new_pc from the mapping.
  - excepttype_i!=0 and stallreq_from_mem=1: latch code and mapped PC into the pending registers, go to WAIT_MEM.
  - Exceptions are captured in RUN only.
- WAIT_MEM:
  - stall follows requests (mem active, so 6'b011111).
  - Ignore excepttype_i.
  - When stallreq_from_mem=0: go to FLUSH with new_pc=pending PC.
- FLUSH:
  - flush=1 for exactly one cycle, stall=0.
  - Next state is RUN unconditionally; flush returns to 0 and new_pc holds its value.
  - Latency: exception seen at edge N with no MEM stall gives flush=1 during cycle N+1.
- Watchdog:
  - Counter increments on each cycle with stall[0]=1 in RUN/WAIT_MEM.
  - Counter clears on any cycle with stall[0]=0 or in FLUSH.
  - When the counter reaches STALL_TIMEOUT-1 while stalled: stall_timeout pulses for 1 cycle, the sticky bit sets, and the counter saturates (no repeat pulse) until the stall drops.
- A simultaneous exception and stall request in RUN produces, that cycle, the stall vector from the requests; flush follows next cycle (or after the MEM stall ends).
- rst asserted in WAIT_MEM or FLUSH discards the pending exception; no flush occurs after reset.

Decomposition:
- Shared defines file gets:
  - stall-vector constants (STALL_IF/ID/EX/MEM)
  - exception code constants (EXC_INT, EXC_SYSCALL, EXC_INV, EXC_OV, EXC_TRAP, EXC_ERET)
  - state encodings
  - existing `RstEnable`, `ZeroWord`, `RegBus`.
- One sub-module is natural: stall_watchdog (counter, saturate, pulse, sticky).

Test Plan:
1. Reset: rst=1 for 2 cycles with all stallreqs=1 -> stall=0, flush=0, new_pc=0, sticky=0.
2. Priority: stallreq_from_id=1 and stallreq_from_if=1 -> stall=6'b000111; add stallreq_from_mem=1 -> 6'b011111.
3. Immediate syscall: excepttype_i=0x8 for one cycle, no stalls -> next cycle flush=1, new_pc=0x40, stall=0; following cycle flush=0.
4. Deferred ERET: cp0_epc_i=0x0000_1234, excepttype_i=0xe with stallreq_from_mem=1 held 3 cycles -> stall=6'b011111 for 3 cycles, no flush; flush=1 with new_pc=0x1234 the cycle after mem stall drops.
5. Watchdog: STALL_TIMEOUT=4, stallreq_from_ex held 10 cycles -> stall_timeout pulses once on 4th stalled cycle; sticky=1 until rst.
6. Reset mid-deferral: enter WAIT_MEM with code 0x1, assert rst one cycle -> no flush ever; state RUN, stall=0.
